// File: rtl/data_mem_interface.sv
// data_mem_interface: load/store unit between the core and a 64-bit memory bus.
// Handles access sizes B/H/W/D (signed and unsigned loads), lane shifting of
// store data, byte-enable generation, alignment and legality checks, and a
// bounded wait for the bus acknowledge.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   data_mem_read_enable    core load request
//   data_mem_write_enable   core store request
//   addr, funct3, wdata     byte address, access size/sign, right-aligned store data
//   rdata                   registered load result (sign/zero-extended)
//   stall                   core holds PC and inputs while high
//   misaligned_exc          one-cycle pulse on a misaligned request
//   access_fault            one-cycle pulse on illegal funct3, both enables, or timeout
//   mem_req, mem_we         bus request / write strobe
//   mem_addr, mem_wdata     doubleword address and lane-shifted store data
//   mem_byte_en             byte-lane enables
//   mem_ack, mem_rdata      bus completion pulse and read data
module data_mem_interface #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        data_mem_read_enable,
    input  logic        data_mem_write_enable,
    input  logic [63:0] addr,
    input  logic [2:0]  funct3,
    input  logic [63:0] wdata,
    output logic [63:0] rdata,
    output logic        stall,
    output logic        misaligned_exc,
    output logic        access_fault,
    output logic        mem_req,
    output logic        mem_we,
    output logic [63:0] mem_addr,
    output logic [63:0] mem_wdata,
    output logic [7:0]  mem_byte_en,
    input  logic        mem_ack,
    input  logic [63:0] mem_rdata
);

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_t;

    // Last BUSY cycle index that may still receive the acknowledge.
    localparam logic [7:0] TimeoutLast = 8'(TIMEOUT_CYCLES - 1);

    state_t      r_state;
    logic [63:0] r_rdata;
    logic        r_we;
    logic [63:0] r_addr;
    logic [63:0] r_wdata;
    logic [7:0]  r_be;
    logic [2:0]  r_funct3;
    logic [2:0]  r_off;
    logic [7:0]  r_cnt;
    logic        r_tmo;

    logic        w_idle;
    logic        w_req;
    logic        w_fault_req;
    logic        w_mis;
    logic        w_accept;
    logic [7:0]  w_mask;
    logic [7:0]  w_be;
    logic [63:0] w_wdata;
    logic [63:0] w_shifted;
    logic [63:0] w_load;

    // Request classification, only meaningful while idle.
    always_comb begin
        w_idle      = (r_state == StIdle);
        w_req       = data_mem_read_enable | data_mem_write_enable;
        w_fault_req = (data_mem_read_enable & data_mem_write_enable)
                    | (data_mem_read_enable & (funct3 == 3'b111))
                    | (data_mem_write_enable & funct3[2]);
        unique case (funct3[1:0])
            2'b00:   w_mis = 1'b0;
            2'b01:   w_mis = addr[0];
            2'b10:   w_mis = |addr[1:0];
            default: w_mis = |addr[2:0];
        endcase
        w_accept = w_idle & w_req & ~w_fault_req & ~w_mis;
    end

    // Byte lanes and store data placed at the addressed lane.
    always_comb begin
        unique case (funct3[1:0])
            2'b00:   w_mask = 8'h01;
            2'b01:   w_mask = 8'h03;
            2'b10:   w_mask = 8'h0F;
            default: w_mask = 8'hFF;
        endcase
        w_be    = w_mask << addr[2:0];
        w_wdata = wdata << {addr[2:0], 3'b000};
    end

    // Load data brought down to lane 0, truncated and extended.
    always_comb begin
        w_shifted = mem_rdata >> {r_off, 3'b000};
        unique case (r_funct3)
            3'b000:  w_load = {{56{w_shifted[7]}}, w_shifted[7:0]};
            3'b001:  w_load = {{48{w_shifted[15]}}, w_shifted[15:0]};
            3'b010:  w_load = {{32{w_shifted[31]}}, w_shifted[31:0]};
            3'b100:  w_load = {56'd0, w_shifted[7:0]};
            3'b101:  w_load = {48'd0, w_shifted[15:0]};
            3'b110:  w_load = {32'd0, w_shifted[31:0]};
            default: w_load = w_shifted;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= StIdle;
            r_rdata  <= 64'd0;
            r_we     <= 1'b0;
            r_addr   <= 64'd0;
            r_wdata  <= 64'd0;
            r_be     <= 8'd0;
            r_funct3 <= 3'd0;
            r_off    <= 3'd0;
            r_cnt    <= 8'd0;
            r_tmo    <= 1'b0;
        end else begin
            r_tmo <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (w_accept) begin
                        r_state  <= StBusy;
                        r_we     <= data_mem_write_enable;
                        r_addr   <= {addr[63:3], 3'b000};
                        r_wdata  <= w_wdata;
                        r_be     <= w_be;
                        r_funct3 <= funct3;
                        r_off    <= addr[2:0];
                        r_cnt    <= 8'd0;
                    end
                end
                StBusy: begin
                    // An ack on the final allowed cycle still wins over the timeout.
                    if (mem_ack) begin
                        if (!r_we) begin
                            r_rdata <= w_load;
                        end
                        r_state <= StDone;
                    end else if (r_cnt == TimeoutLast) begin
                        r_tmo   <= 1'b1;
                        r_state <= StDone;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                StDone: r_state <= StIdle;
                default: r_state <= StIdle;
            endcase
        end
    end

    // Request-dependent outputs are gated by rst_n so they read 0 throughout reset.
    always_comb begin
        rdata          = r_rdata;
        mem_req        = (r_state == StBusy);
        stall          = rst_n & ((r_state == StBusy) | w_accept);
        misaligned_exc = rst_n & w_idle & w_req & ~w_fault_req & w_mis;
        access_fault   = rst_n & ((w_idle & w_req & w_fault_req) | r_tmo);
        mem_we         = r_we;
        mem_addr       = r_addr;
        mem_wdata      = r_wdata;
        mem_byte_en    = r_be;
    end

endmodule

// File: doc/data_mem_interface.md
DATA_MEM_INTERFACE -- requirements
Module: data_mem_interface

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, giving the maximum BUSY cycles to wait for mem_ack (range 1..255).
REQ-002 SHALL have the following ports (name, direction, width, meaning):
- clk  in  1  single clock; all state on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- data_mem_read_enable  in  1  core load request.
- data_mem_write_enable  in  1  core store request.
- addr  in  64  byte address from the ALU.
- funct3  in  3  access size/sign.
- wdata  in  64  store data (rs2), right-aligned.
- rdata  out  64  load result, sign/zero-extended.
- stall  out  1  core shall hold PC and inputs while high.
- misaligned_exc  out  1  misaligned-access pulse.
- access_fault  out  1  illegal-funct3, conflicting-enables or timeout pulse.
- mem_req  out  1  bus request.
- mem_we  out  1  bus write.
- mem_addr  out  64  doubleword address, bits[2:0] always 0.
- mem_wdata  out  64  lane-shifted store data.
- mem_byte_en  out  8  byte-lane enables.
- mem_ack  in  1  bus completion, one-cycle pulse.
- mem_rdata  in  64  bus read data, valid with mem_ack.

Function
REQ-003 SHALL implement FSM IDLE -> BUSY -> DONE -> IDLE.
REQ-004 SHALL decode funct3 as: 000 B, 001 H, 010 W, 011 D, 100 BU, 101 HU, 110 WU; for stores only 000-011 are legal.
REQ-005 SHALL treat an access as misaligned when addr is not a multiple of its size: H needs addr[0]=0; W needs addr[1:0]=0; D needs addr[2:0]=0.
REQ-006 In IDLE, a legal aligned request (exactly one enable high) SHALL register addr/funct3/wdata/we, assert stall combinationally in the same cycle, and go to BUSY.
REQ-007 In IDLE, a misaligned request SHALL assert misaligned_exc for that cycle with stall=0, no bus request and no state change.
REQ-008 In IDLE, an illegal funct3, or both enables high, SHALL assert access_fault for that cycle with stall=0 and no bus request; when misaligned and illegal coincide, access_fault SHALL take priority.
REQ-009 In BUSY, mem_req SHALL be 1 and stall SHALL be 1; mem_addr/mem_we/mem_wdata/mem_byte_en SHALL be driven from registers and held stable until mem_ack.
REQ-010 mem_byte_en SHALL equal the size mask (B=0x01, H=0x03, W=0x0F, D=0xFF) shifted left by addr[2:0]; mem_wdata SHALL equal wdata shifted left by 8*addr[2:0].
REQ-011 On mem_ack in BUSY, the block SHALL register rdata = (mem_rdata >> 8*addr[2:0]) truncated to size, then sign- or zero-extended per funct3, and go to DONE; for stores, rdata SHALL be unchanged.
REQ-012 In DONE, stall SHALL be 0 and mem_req SHALL be 0; core inputs SHALL be ignored; next state SHALL be IDLE unconditionally; rdata SHALL hold until the next completed load.
REQ-013 The BUSY cycle counter SHALL start at 0 on entry; if it reaches TIMEOUT_CYCLES without mem_ack, the block SHALL drop mem_req, pulse access_fault for one cycle and go to DONE, leaving rdata unchanged.
REQ-014 A mem_ack outside BUSY SHALL be ignored.
REQ-015 mem_ack in the same cycle the counter reaches TIMEOUT_CYCLES SHALL be treated as success, with no fault.
REQ-016 Minimum latency SHALL be 3 cycles from request to core advance: IDLE, BUSY with ack, then DONE.

Reset
REQ-017 While rst_n=0, the block SHALL force state IDLE and set rdata=0, stall=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, mem_byte_en=0, misaligned_exc=0, access_fault=0 and counter=0, all immediately (asynchronous).
REQ-018 Reset asserted during BUSY SHALL drop mem_req the same instant; a late mem_ack after reset release SHALL be ignored.

Verification
REQ-019 LD at addr 0x1000, ack after 2 cycles with mem_rdata=0x8877665544332211 -> mem_addr=0x1000, mem_byte_en=0xFF, rdata=0x8877665544332211, stall high for exactly 3 cycles.
REQ-020 LB at addr 0x1003, mem_rdata=0x00000000_80000000 -> mem_byte_en=0x08, rdata=0xFFFFFFFFFFFFFF80; the same access with LBU -> rdata=0x80.
REQ-021 SH at addr 0x2006 with wdata=0xABCD -> mem_we=1, mem_addr=0x2000, mem_byte_en=0xC0, mem_wdata[63:48]=0xABCD, rdata unchanged.
REQ-022 LW at addr 0x1002 -> misaligned_exc=1 for one cycle, mem_req never asserted, stall=0.
REQ-023 Store with funct3=100, or both enables high -> access_fault=1 for one cycle, no bus request.
REQ-024 Never ack with TIMEOUT_CYCLES=4 -> mem_req high for 4 cycles, then access_fault pulse, then DONE->IDLE; a separate run asserting rst_n=0 mid-BUSY -> mem_req=0 immediately and state IDLE.
